// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- common-data-bus arbiter for the Tomasulo core.
//   Collects results from N_SRC functional units, each buffered in a private
//   2-entry FIFO, and drives one registered CDB broadcast per cycle using a
//   round-robin grant. A misprediction flush drops every buffered result.
// Ports:
//   clk, rst (async, active low), flush (sync, active high)
//   src_valid/src_rob_id/src_value : packed per-source result offers
//   src_ready                      : per-source accept (FIFO not full)
//   cdb_valid/cdb_rob_id/cdb_value : registered broadcast
//   cdb_src                        : index of the source being broadcast

// cdb_src_fifo -- per-source 2-entry result FIFO.
//   push_i is qualified here with ready_o and flush_i; pop_i is only raised
//   by the arbiter when req_o is high.
module cdb_src_fifo #(
  parameter int EW = 38
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [EW-1:0] din_i,
  input  logic          pop_i,
  output logic          ready_o,
  output logic          req_o,
  output logic [EW-1:0] head_o
);
  logic [EW-1:0] mem_q [2];
  logic          head_q, tail_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;

  assign ready_o = (cnt_q < 2'd2);
  assign req_o   = (cnt_q != 2'd0);
  assign head_o  = mem_q[head_q];
  assign push    = push_i & ready_o & ~flush_i;
  assign pop     = pop_i & ~flush_i;

  // Push and pop together leave the count unchanged; with one entry the
  // old head leaves while the new entry lands in the other slot.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= din_i;
        tail_q        <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int N_SRC        = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int ROB_ID_WIDTH = 6,
  localparam int SW          = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int DW          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*ROB_ID_WIDTH-1:0] src_rob_id,
  input  logic [N_SRC*DW-1:0]           src_value,
  output logic [N_SRC-1:0]              src_ready,
  output logic                          cdb_valid,
  output logic [ROB_ID_WIDTH-1:0]       cdb_rob_id,
  output logic [DW-1:0]                 cdb_value,
  output logic [SW-1:0]                 cdb_src
);
  localparam int EW = ROB_ID_WIDTH + DW;

  logic [N_SRC-1:0]         req, gnt_oh;
  logic [N_SRC-1:0][EW-1:0] head;
  logic                     gnt_vld;
  logic [SW-1:0]            gnt_idx, rr_q, rr_d;
  logic                     cdb_valid_q;
  logic [ROB_ID_WIDTH-1:0]  cdb_rob_q;
  logic [DW-1:0]            cdb_val_q;
  logic [SW-1:0]            cdb_src_q;

  genvar i;
  generate
    for (i = 0; i < N_SRC; i++) begin : g_src
      assign gnt_oh[i] = gnt_vld && (gnt_idx == SW'(i));
      cdb_src_fifo #(.EW(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (src_valid[i]),
        .din_i   ({src_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH], src_value[i*DW +: DW]}),
        .pop_i   (gnt_oh[i]),
        .ready_o (src_ready[i]),
        .req_o   (req[i]),
        .head_o  (head[i])
      );
    end
  endgenerate

  // Round-robin search: first requester at or after rr_q, wrapping.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      j = (int'(rr_q) + k) % N_SRC;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(j);
      end
    end
    rr_d = (gnt_idx == SW'(N_SRC - 1)) ? '0 : gnt_idx + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_val_q   <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
    end else if (gnt_vld) begin
      rr_q                     <= rr_d;
      cdb_valid_q              <= 1'b1;
      {cdb_rob_q, cdb_val_q}   <= head[gnt_idx];
      cdb_src_q                <= gnt_idx;
    end else begin
      // Idle: payload holds, only the valid drops.
      cdb_valid_q <= 1'b0;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_q;
  assign cdb_value  = cdb_val_q;
  assign cdb_src    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter -- directed bench for cdb_arbiter (N_SRC=4, ROB_ID_WIDTH=6).
//   Inputs change 1 time unit after each rising edge; outputs are checked at
//   the same point, i.e. after the edge has settled.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 6;

  logic               clk, rst, flush;
  logic [N-1:0]       v;
  logic [N-1:0][RW-1:0] rid;
  logic [N-1:0][31:0] val;
  logic [N-1:0]       src_ready;
  logic               cdb_valid;
  logic [RW-1:0]      cdb_rob_id;
  logic [31:0]        cdb_value;
  logic [1:0]         cdb_src;

  int nassert = 0;
  int nfail   = 0;

  cdb_arbiter #(.N_SRC(N), .FIFO_DEPTH(2), .ROB_ID_WIDTH(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .src_valid  (v),
    .src_rob_id (rid),
    .src_value  (val),
    .src_ready  (src_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bc(input string tag, input logic [1:0] s, input logic [RW-1:0] r);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_src"},   64'(cdb_src),   64'(s));
    chk({tag, "_rob"},   64'(cdb_rob_id), 64'(r));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(cdb_valid),  64'd0);
    chk({tag, "_rob"},   64'(cdb_rob_id), 64'd0);
    chk({tag, "_value"}, 64'(cdb_value),  64'd0);
    chk({tag, "_src"},   64'(cdb_src),    64'd0);
    chk({tag, "_ready"}, 64'(src_ready),  64'hF);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; v = '0; rid = '0; val = '0;

    // Reset state
    #2;
    chk_reset_outs("rst");
    #1 rst = 1'b1;
    step();
    chk_reset_outs("rst_rel");

    // Single source: source 2 offers {5, DEADBEEF} for one cycle
    v[2] = 1'b1; rid[2] = 6'd5; val[2] = 32'hDEADBEEF;
    step();
    v = '0;
    chk("single_e0_valid", 64'(cdb_valid), 64'd0);
    step();
    chk_bc("single_e1", 2'd2, 6'd5);
    chk("single_e1_value", 64'(cdb_value), 64'hDEADBEEF);
    step();
    chk("single_e2_valid", 64'(cdb_valid), 64'd0);
    chk("single_hold_rob", 64'(cdb_rob_id), 64'd5);
    chk("single_hold_src", 64'(cdb_src), 64'd2);

    // All-contend from reset: order 0,1,2,3 then idle
    rst = 1'b0; #2 rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b1; rid[k] = RW'(10 + k); val[k] = 32'(100 + k);
    end
    step();
    v = '0;
    for (int k = 0; k < N; k++) begin
      step();
      chk_bc($sformatf("rr%0d", k), 2'(k), RW'(10 + k));
      chk($sformatf("rr%0d_value", k), 64'(cdb_value), 64'(100 + k));
    end
    step();
    chk("rr_idle", 64'(cdb_valid), 64'd0);

    // Back-pressure: rr=0, source 0 first, source 1 fills to 2
    v[0] = 1'b1; rid[0] = 6'd30; v[1] = 1'b1; rid[1] = 6'd20;
    step();                                   // E0: both pushed
    chk("bp_e0_ready1", 64'(src_ready[1]), 64'd1);
    rid[0] = 6'd31; rid[1] = 6'd21;
    step();                                   // E1: pop 30, push 31, push 21
    chk_bc("bp_e1", 2'd0, 6'd30);
    chk("bp_e1_ready1", 64'(src_ready[1]), 64'd0);
    v[0] = 1'b0; rid[1] = 6'd22;
    step();                                   // E2: 22 refused, pop 20
    chk_bc("bp_e2", 2'd1, 6'd20);
    chk("bp_e2_ready1", 64'(src_ready[1]), 64'd1);
    step();                                   // E3: push 22, pop 31
    chk_bc("bp_e3", 2'd0, 6'd31);
    chk("bp_e3_ready1", 64'(src_ready[1]), 64'd0);
    v[1] = 1'b0;
    step();
    chk_bc("bp_e4", 2'd1, 6'd21);
    chk("bp_e4_ready1", 64'(src_ready[1]), 64'd1);
    step();
    chk_bc("bp_e5", 2'd1, 6'd22);
    step();
    chk("bp_idle", 64'(cdb_valid), 64'd0);

    // Streaming: source 3 pushes ids 0..9 back to back
    for (int k = 0; k < 10; k++) begin
      v[3] = 1'b1; rid[3] = RW'(k); val[3] = 32'(k * 3);
      step();
      chk($sformatf("str%0d_ready3", k), 64'(src_ready[3]), 64'd1);
      if (k > 0) chk_bc($sformatf("str%0d", k), 2'd3, RW'(k - 1));
    end
    v = '0;
    step();
    chk_bc("str_last", 2'd3, 6'd9);
    chk("str_last_value", 64'(cdb_value), 64'd27);
    step();
    chk("str_idle", 64'(cdb_valid), 64'd0);

    // Flush: sources 0/1 hold entries, flush while source 2 pushes
    v[0] = 1'b1; rid[0] = 6'd40; v[1] = 1'b1; rid[1] = 6'd50;
    step();
    rid[0] = 6'd41; rid[1] = 6'd51;
    step();
    chk_bc("fl_pre", 2'd0, 6'd40);
    chk("fl_pre_ready1", 64'(src_ready[1]), 64'd0);
    v = '0; v[2] = 1'b1; rid[2] = 6'd60; flush = 1'b1;
    step();
    flush = 1'b0; v = '0;
    chk("fl_valid", 64'(cdb_valid), 64'd0);
    chk("fl_ready", 64'(src_ready), 64'hF);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("fl_quiet%0d", k), 64'(cdb_valid), 64'd0);
    end
    v[3] = 1'b1; rid[3] = 6'd7;
    step();
    v = '0;
    chk("fl_post_e0", 64'(cdb_valid), 64'd0);
    step();
    chk_bc("fl_post", 2'd3, 6'd7);

    // Async reset mid-broadcast, then rr must restart at 0
    v[1] = 1'b1; rid[1] = 6'd33; val[1] = 32'h1234;
    step();
    v = '0;
    step();
    chk_bc("ar_pre", 2'd1, 6'd33);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs("ar");
    #1 rst = 1'b1;
    v[0] = 1'b1; rid[0] = 6'd1; v[3] = 1'b1; rid[3] = 6'd3;
    step();
    v = '0;
    chk("ar_e0_valid", 64'(cdb_valid), 64'd0);
    step();
    chk_bc("ar_first", 2'd0, 6'd1);
    step();
    chk_bc("ar_second", 2'd3, 6'd3);
    step();
    chk("ar_idle", 64'(cdb_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
